// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: frames one byte and shifts it out on btu pulses
module uart_tx_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] out_port,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       btu,
  output logic       doit,
  output logic       tx,
  output logic       txrdy,
  output logic       tx_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [3:0]  LAST_BIT = 4'd10;
  localparam logic [10:0] LINE_IDLE = 11'h7FF;

  state_t      state;
  logic [10:0] shreg;
  logic [3:0]  bit_cnt;
  logic        parity_bit;
  logic        ninth_bit;
  logic [10:0] frame;

  // Even parity covers only the data bits actually sent; odd is its inverse.
  always_comb begin
    parity_bit = (eight ? (^out_port) : (^out_port[6:0])) ^ ohel;
    ninth_bit  = pen ? parity_bit : 1'b1;
    if (eight) begin
      frame = {1'b1, ninth_bit, out_port, 1'b0};
    end else begin
      frame = {1'b1, 1'b1, ninth_bit, out_port[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= LINE_IDLE;
      bit_cnt <= 4'd0;
      tx      <= 1'b1;
      doit    <= 1'b0;
      txrdy   <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state   <= SEND;
            shreg   <= frame;
            tx      <= frame[0];
            bit_cnt <= 4'd0;
            doit    <= 1'b1;
            txrdy   <= 1'b0;
          end
        end
        SEND: begin
          if (btu) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= IDLE;
              shreg   <= LINE_IDLE;
              tx      <= 1'b1;
              bit_cnt <= 4'd0;
              doit    <= 1'b0;
              txrdy   <= 1'b1;
              tx_done <= 1'b1;
            end else begin
              // tx tracks the bit that lands in position 0 after this shift.
              shreg   <= {1'b1, shreg[10:1]};
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

  localparam logic [3:0] K = 4'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic       eight = 1'b0;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       btu;
  logic       btu_force = 1'b0;
  logic       doit;
  logic       tx;
  logic       txrdy;
  logic       tx_done;

  logic [3:0] bcnt;
  int         check_count = 0;
  int         pass_count = 0;

  uart_tx_engine dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .out_port (out_port),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .btu      (btu),
    .doit     (doit),
    .tx       (tx),
    .txrdy    (txrdy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  // Stand-in for btu_counter with terminal count K.
  always @(posedge clk) begin
    if (!rst || !doit || bcnt == K) bcnt <= 4'd0;
    else bcnt <= bcnt + 4'd1;
  end
  assign btu = (doit && bcnt == K) || btu_force;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, {31'd0, tx}, 32'd1);
    check({tag, " txrdy"}, {31'd0, txrdy}, 32'd1);
    check({tag, " doit"}, {31'd0, doit}, 32'd0);
    check({tag, " tx_done"}, {31'd0, tx_done}, 32'd0);
  endtask

  // Called at a negedge; load is accepted on the following posedge.
  // Inputs are then scrambled to show they are sampled only at acceptance.
  task automatic start_load(input logic [7:0] d, input logic e, input logic p, input logic o);
    load = 1'b1; out_port = d; eight = e; pen = p; ohel = o;
    @(negedge clk);
    load = 1'b0; out_port = ~d; eight = ~e; pen = ~p; ohel = ~o;
  endtask

  // Entered at cycle L+1, returns at cycle L+45 after the end-of-frame checks.
  task automatic check_frame(input string tag, input logic [10:0] exp, input int busy_idx);
    for (int i = 0; i < 44; i++) begin
      check($sformatf("%s bit%0d c%0d tx", tag, i / 4, i % 4), {31'd0, tx}, {31'd0, exp[i / 4]});
      check($sformatf("%s c%0d busy", tag, i), {30'd0, doit, txrdy}, 32'd2);
      check($sformatf("%s c%0d tx_done", tag, i), {31'd0, tx_done}, 32'd0);
      if (i == busy_idx) begin
        load = 1'b1; out_port = 8'hFF;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check({tag, " end tx_done"}, {31'd0, tx_done}, 32'd1);
    check({tag, " end txrdy"}, {31'd0, txrdy}, 32'd1);
    check({tag, " end doit"}, {31'd0, doit}, 32'd0);
    check({tag, " end tx"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load = 1'($urandom_range(0, 1));
      out_port = 8'($urandom_range(0, 255));
      eight = 1'($urandom_range(0, 1));
      pen = 1'($urandom_range(0, 1));
      ohel = 1'($urandom_range(0, 1));
      btu_force = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle($sformatf("reset%0d", i));
    end
    load = 1'b0; btu_force = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle("post reset");

    // btu while idle must not move anything
    btu_force = 1'b1;
    repeat (2) @(negedge clk);
    btu_force = 1'b0;
    check_idle("idle btu");

    // 0x55 8E1, a busy 0xFF load mid-frame, then chained straight into 7O1
    start_load(8'h55, 1'b1, 1'b1, 1'b0);
    check_frame("8e1", 11'b10010101010, 20);
    start_load(8'hA5, 1'b0, 1'b1, 1'b1);
    check_frame("7o1", 11'b11001001010, 43);
    @(negedge clk);
    check_idle("after 7o1");
    check("after 7o1 no 2nd done", {31'd0, tx_done}, 32'd0);

    start_load(8'h00, 1'b0, 1'b0, 1'b0);
    check_frame("7n", 11'b11100000000, -1);
    @(negedge clk);
    check_idle("after 7n");

    // Reset during bit 4 abandons the frame without tx_done
    start_load(8'h55, 1'b1, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    check("mid bit4 tx", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle("mid reset");
    repeat (3) begin
      @(negedge clk);
      check_idle("post mid reset");
    end

    start_load(8'h55, 1'b1, 1'b0, 1'b0);
    check_frame("8n", 11'b11010101010, -1);
    @(negedge clk);
    check_idle("final");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
